// File: rtl/lane_sched_32_8_pkg.sv
// Shared definitions for the capa_fisica lane blocks: state encodings, idle fill byte,
// lane widths and the registered beat payload presented on the 8-bit lane.
package lane_sched_32_8_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned REM_W  = WORD_W - BYTE_W;

  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'hBC;
  localparam logic [IDX_W-1:0]  LAST_IDX          = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } lane_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              valid;
  } lane_beat_t;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  function automatic logic arb_pick(input logic v0, input logic v1, input logic last_sel);
    return (v0 && v1) ? ~last_sel : v1;
  endfunction

endpackage

// File: rtl/ser_shift_32_8.sv
// 32->8 serializer: loads a word, emits it MSB byte first with a 2-bit byte index,
// and falls back to the idle fill byte when drained.
module ser_shift_32_8
  import lane_sched_32_8_pkg::*;
#(
  parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              shift_i,
  input  logic              drain_i,
  output lane_beat_t        beat_o
);

  logic [REM_W-1:0] rem_q, rem_d;
  lane_beat_t       beat_q, beat_d;

  // Remaining bytes are held locally so the source word may change after the load.
  always_comb begin
    rem_d  = rem_q;
    beat_d = beat_q;
    if (load_i) begin
      beat_d.data  = word_i[WORD_W-1 -: BYTE_W];
      beat_d.idx   = '0;
      beat_d.valid = 1'b1;
      rem_d        = word_i[REM_W-1:0];
    end else if (shift_i) begin
      beat_d.data  = rem_q[REM_W-1 -: BYTE_W];
      beat_d.idx   = beat_q.idx + IDX_W'(1);
      rem_d        = {rem_q[REM_W-BYTE_W-1:0], BYTE_W'(0)};
    end else if (drain_i) begin
      beat_d.data  = IDLE_BYTE;
      beat_d.idx   = '0;
      beat_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q        <= '0;
      beat_q.data  <= IDLE_BYTE;
      beat_q.idx   <= '0;
      beat_q.valid <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      beat_q <= beat_d;
    end
  end

  assign beat_o = beat_q;

endmodule

// File: rtl/lane_sched_32_8.sv
// Two-requester word scheduler for the 32->8 lane: round-robin arbitration per word,
// with a new word accepted only in a slot so back-to-back words stream without bubbles.
module lane_sched_32_8
  import lane_sched_32_8_pkg::*;
#(
  parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in0,
  input  logic              valid_in0,
  output logic              ready_out0,
  input  logic [WORD_W-1:0] data_in1,
  input  logic              valid_in1,
  output logic              ready_out1,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic [IDX_W-1:0]  byte_idx,
  output logic              sel_out
);

  lane_state_e state_q;
  logic        last_sel_q;
  logic        sel_q;
  lane_beat_t  beat;

  logic slot_c;
  logic grant_c;
  logic accept_c;
  logic shift_c;
  logic drain_c;

  // Slot qualification is gated by reset so no ready leaks out while held in reset.
  always_comb begin
    slot_c   = reset && ((state_q == ST_IDLE) || (beat.idx == LAST_IDX));
    grant_c  = arb_pick(valid_in0, valid_in1, last_sel_q);
    accept_c = slot_c && (valid_in0 || valid_in1);
    shift_c  = (state_q == ST_SEND) && (beat.idx != LAST_IDX);
    drain_c  = (state_q == ST_SEND) && (beat.idx == LAST_IDX) && !accept_c;
  end

  assign ready_out0 = accept_c && !grant_c;
  assign ready_out1 = accept_c &&  grant_c;

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      last_sel_q <= 1'b1;
      sel_q      <= 1'b0;
    end else begin
      if (accept_c) begin
        state_q    <= ST_SEND;
        last_sel_q <= grant_c;
        sel_q      <= grant_c;
      end else if (drain_c) begin
        state_q    <= ST_IDLE;
      end
    end
  end

  ser_shift_32_8 #(
    .IDLE_BYTE (IDLE_BYTE)
  ) u_ser (
    .clk     (clk_4f),
    .rst_n   (reset),
    .load_i  (accept_c),
    .word_i  (grant_c ? data_in1 : data_in0),
    .shift_i (shift_c),
    .drain_i (drain_c),
    .beat_o  (beat)
  );

  assign data_out  = beat.data;
  assign valid_out = beat.valid;
  assign byte_idx  = beat.idx;
  assign sel_out   = sel_q;

endmodule
